// File: rtl/alpha_switch_sequencer.sv
// HDR/HSNR channel-select sequencer: strobe-aligned switching with dwell and settle windows.
// Optional macro ALPHA_SEQ_HOLD_EN: hold sample_out during settle instead of blanking sample_valid.
module alpha_switch_sequencer #(
    parameter int unsigned DWELL_W        = 8,
    parameter int unsigned SETTLE_SAMPLES = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               CLK_24M,
    input  logic               reset,
    input  logic               sample_strobe,
    input  logic               alpha_req,
    input  logic               force_en,
    input  logic               force_alpha,
    input  logic [DWELL_W-1:0] dwell_min,
    input  logic [10:0]        sample_in,
    output logic               alpha_sel,
    output logic [10:0]        sample_out,
    output logic               sample_valid,
    output logic               switching,
    output logic [CNT_W-1:0]   switch_count
);

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_STABLE,
        ST_PENDING,
        ST_SETTLE
    } state_t;

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [10:0]          out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 switching_q;

    logic req;
    logic dwell_ok;
    logic do_switch;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        count_d   = count_q;
        dwell_d   = dwell_q;
        settle_d  = settle_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        do_switch = 1'b0;

        req      = force_en ? force_alpha : alpha_req;
        dwell_ok = force_en || (dwell_q >= dwell_min);

        case (state_q)
            ST_STABLE: begin
                if ((req != sel_q) && dwell_ok) begin
                    if (sample_strobe) do_switch = 1'b1;
                    else               state_d   = ST_PENDING;
                end else if (sample_strobe && (dwell_q != '1)) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            ST_PENDING: begin
                // A cancelled request keeps the dwell already accumulated.
                if (req == sel_q)       state_d   = ST_STABLE;
                else if (sample_strobe) do_switch = 1'b1;
            end
            ST_SETTLE: begin
                if (sample_strobe) begin
                    if (settle_q == SETTLE_W'(1)) state_d  = ST_STABLE;
                    else                          settle_d = settle_q - SETTLE_W'(1);
                end
            end
            default: state_d = ST_STABLE;
        endcase

        if (do_switch) begin
            sel_d    = ~sel_q;
            count_d  = count_q + CNT_W'(1);
            dwell_d  = '0;
            settle_d = SETTLE_W'(SETTLE_SAMPLES);
            state_d  = ST_SETTLE;
        end

        if (sample_strobe) begin
            if (state_q == ST_SETTLE) begin
`ifdef ALPHA_SEQ_HOLD_EN
                valid_d = 1'b1;
`else
                out_d   = sample_in;
                valid_d = 1'b0;
`endif
            end else begin
                out_d   = sample_in;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            state_q     <= ST_STABLE;
            sel_q       <= 1'b0;
            count_q     <= '0;
            dwell_q     <= '0;
            settle_q    <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            dwell_q     <= dwell_d;
            settle_q    <= settle_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            switching_q <= (state_d != ST_STABLE);
        end
    end

    assign alpha_sel    = sel_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign switching    = switching_q;
    assign switch_count = count_q;

endmodule
